multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath. It steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables each cycle.
//  It handshakes with a shared instruction/data memory via mem_ready and supports
//  an external stall. It counts retired instructions.
// PARAMETERS
//  RET_W        32   width of retired-instruction counter
//  MEM_TIMEOUT  255  max wait cycles on mem_ready (used only with MCU_WATCHDOG_EN)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  opcode       in   7      instr[6:0] from IR; valid from DECODE onward
//  zero         in   1      ALU zero flag, sampled in EXEC for branches
//  mem_ready    in   1      memory completed current read/write this cycle
//  stall        in   1      freeze sequencer
//  PCWrite      out  1      unconditional PC update
//  PCWriteCond  out  1      PC update if branch taken
//  IorD         out  1      0=PC addresses memory, 1=ALU result
//  IRWrite      out  1      load instruction register
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  RegWrite     out  1      register file write
//  MemToReg     out  2      WB mux: 00 ALU, 01 mem data, 10 PC+4
//  ALUSrc       out  1      0=rs2, 1=imm
//  ALUOp        out  2      00 add, 10 funct-decoded, 11 branch compare
//  illegal_op   out  1      1-cycle pulse when an unknown opcode is seen in DECODE
//  instret      out  RET_W  retired-instruction count
// BEHAVIOUR
//  Interface: one clock, clk. reset is synchronous and active-high.
//  - reset high: at the edge, state<=FETCH, op_q<=0, instret<=0.
//    While reset is high, all outputs are forced to 0 combinationally,
//    including MemWrite, so a write in flight is dropped. Abort takes effect mid-instruction.
//  - Outputs are Moore, decoded from the state register and op_q. op_q is the opcode latched on the DECODE->EXEC edge.
//  - FETCH: MemRead=1, IorD=0. Hold until mem_ready=1. In that cycle IRWrite=1 and PCWrite=1 (PC+4), then go to DECODE.
//  - DECODE: 1 cycle, register read.
//    Opcodes R 0110011, I 0010011, Ld 0000011, St 0100011, Br 1100011 and JAL 1101111 go to EXEC.
//    Any other opcode pulses illegal_op and goes to FETCH; the instruction is not retired.
//  - EXEC: ALUSrc/ALUOp per opcode (R:0/10, I:1/10, Ld/St:1/00, Br:0/11, JAL:0/10).
//    Ld/St go to MEM. R, I and JAL go to WB.
//    Br: PCWriteCond=1. The PC loads the target iff zero=1. Then FETCH, and the branch retires.
//  - MEM: IorD=1. Ld drives MemRead=1; St drives MemWrite=1.
//    The request is held until mem_ready=1. Ld then goes to WB. St goes to FETCH and retires.
//  - WB: RegWrite=1. MemToReg is 01 for Ld, 10 for JAL, 00 otherwise. Then FETCH; the instruction retires.
//  - Latency with mem_ready=1 on the first cycle: Br 3, R/I/St/JAL 4, Ld 5 cycles.
//  - stall=1: no state transition. PCWrite, PCWriteCond, IRWrite and RegWrite are suppressed.
//    MemRead/MemWrite/IorD are held. stall and mem_ready together: stall wins, and
//    mem_ready must reassert after stall drops.
//  - instret increments by 1 on each retire edge and wraps modulo 2^RET_W without saturating.
//  - States not in the enumeration recover to FETCH on the next edge.
// CONFIGURATION
//  MCU_WATCHDOG_EN defined: a wait counter counts cycles in FETCH/MEM with mem_ready=0 and stall=0.
//    The counter clears on any state change.
//    When it reaches MEM_TIMEOUT, the FSM drops the request, pulses an extra
//    output mem_timeout (1 bit, reset 0) for 1 cycle, and goes to FETCH with no retire.
//  Not defined: no counter and no mem_timeout port; a wait on mem_ready is unbounded.
// STRUCTURE
//  Package rv_ctrl_pkg holds:
//    - opcode localparams (OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL);
//    - the state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB), 3 bits;
//    - ALUOp codes and MemToReg codes.
//  Single module with two parts:
//    - sequential: state, op_q, instret, watchdog counter;
//    - combinational: output decode.
//  No sub-module; the watchdog is inline under `ifdef.
// TESTING
//  1. R-type 0110011, mem_ready always 1 -> FETCH,DECODE,EXEC,WB.
//     RegWrite=1 only in cycle 4; instret 0->1.
//  2. Load 0000011, mem_ready low for 3 cycles in MEM -> MemRead/IorD=1 held for 4 cycles.
//     WB MemToReg=01; 8 cycles total.
//  3. Branch with zero=1, then with zero=0 -> PCWriteCond=1 in EXEC both times.
//     3 cycles each; instret +2.
//  4. Opcode 1111111 -> illegal_op pulses in DECODE; next state FETCH; instret unchanged.
//  5. Store, with stall=1 asserted in the same cycle as mem_ready=1 -> stays in MEM with MemWrite=1.
//     Completes only on a later mem_ready with stall=0.
//  6. reset=1 during MEM of a store -> MemWrite=0 in the same cycle; FETCH and instret=0 after the edge.
//     With MCU_WATCHDOG_EN and MEM_TIMEOUT=4, mem_ready held at 0 in FETCH ->
//     mem_timeout pulses after 4 cycles and state returns to FETCH.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared definitions for the RV32I multi-cycle control sequencer.
//   - RV32I major opcodes handled by the sequencer
//   - sequencer state enumeration (3 bits)
//   - ALUOp and MemToReg encodings driven to the datapath
//   - op_legal(): true for the opcodes the sequencer can execute
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_BR    = 2'b11;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
           (op == OP_ST) || (op == OP_BR) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle sequencer for an RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with a
// shared instruction/data memory via mem_ready, honours an external stall and
// counts retired instructions.
//
// Optional feature macro: MCU_WATCHDOG_EN
//   defined   -> memory-wait watchdog plus the mem_timeout output port
//   undefined -> waits on mem_ready are unbounded, no mem_timeout port
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   opcode                  instr[6:0] from IR, valid from DECODE onward
//   zero                    ALU zero flag; the datapath gates PCWriteCond with it
//   mem_ready, stall        memory completion, sequencer freeze
//   PCWrite .. ALUOp        datapath enables / mux selects
//   illegal_op              1-cycle pulse for an unknown opcode in DECODE
//   mem_timeout             watchdog expiry pulse (MCU_WATCHDOG_EN only)
//   instret                 retired-instruction counter
//
// state    | meaning
// S_FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
// S_DECODE | register read, opcode check
// S_EXEC   | ALU operation; branches resolve and retire here
// S_MEM    | data access at ALU address, held until mem_ready
// S_WB     | register file write, instruction retires
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int RET_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             stall,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       MemToReg,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             illegal_op,
`ifdef MCU_WATCHDOG_EN
  output logic             mem_timeout,
`endif
  output logic [RET_W-1:0] instret
);

  state_t             state, state_nx;
  logic [6:0]         op_q;
  logic [RET_W-1:0]   instret_q;
  logic               retire;
  logic               wd_timeout;

  // zero is consumed by the datapath together with PCWriteCond, not here
  logic unused_ok;
  assign unused_ok = ^{zero, (MEM_TIMEOUT == 0)};

`ifdef MCU_WATCHDOG_EN
  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_wait;

  assign wd_wait    = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready && !stall;
  assign wd_timeout = wd_wait && (wd_cnt == '0);

  // Down-counter reloaded on every state change (or expiry); expiry fires on
  // the wait cycle after MEM_TIMEOUT waiting cycles have been counted.
  always_ff @(posedge clk) begin
    if (reset || (state_nx != state) || wd_timeout) begin
      wd_cnt <= WD_W'(MEM_TIMEOUT);
    end else if (wd_wait) begin
      wd_cnt <= wd_cnt - WD_W'(1);
    end
  end

  assign mem_timeout = !reset && wd_timeout;
`else
  assign wd_timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready && !stall) state_nx = S_DECODE;
      S_DECODE: if (!stall) state_nx = op_legal(opcode) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (!stall) begin
          if ((op_q == OP_LD) || (op_q == OP_ST)) begin
            state_nx = S_MEM;
          end else if (op_q == OP_BR) begin
            state_nx = S_FETCH;
            retire   = 1'b1;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_MEM: begin
        if (mem_ready && !stall) begin
          if (op_q == OP_LD) begin
            state_nx = S_WB;
          end else begin
            state_nx = S_FETCH;
            retire   = 1'b1;
          end
        end
      end
      S_WB: begin
        if (!stall) begin
          state_nx = S_FETCH;
          retire   = 1'b1;
        end
      end
      default: state_nx = S_FETCH;
    endcase
    if (wd_timeout) begin
      state_nx = S_FETCH;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      op_q      <= '0;
      instret_q <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_DECODE) && (state_nx == S_EXEC)) op_q <= opcode;
      if (retire) instret_q <= instret_q + RET_W'(1);
    end
  end

  // Reset blanks every output immediately so an in-flight write is dropped.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = M2R_ALU;
    ALUSrc      = 1'b0;
    ALUOp       = ALUOP_ADD;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = !wd_timeout;
          if (mem_ready && !stall) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_DECODE: illegal_op = !stall && !op_legal(opcode);
        S_EXEC: begin
          case (op_q)
            OP_R:   ALUOp = ALUOP_FUNCT;
            OP_I:   begin ALUSrc = 1'b1; ALUOp = ALUOP_FUNCT; end
            OP_LD,
            OP_ST:  ALUSrc = 1'b1;
            OP_BR:  begin ALUOp = ALUOP_BR; PCWriteCond = !stall; end
            OP_JAL: ALUOp = ALUOP_FUNCT;
            default: ;
          endcase
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = (op_q == OP_LD) && !wd_timeout;
          MemWrite = (op_q == OP_ST) && !wd_timeout;
        end
        S_WB: begin
          RegWrite = !stall;
          if (op_q == OP_LD)       MemToReg = M2R_MEM;
          else if (op_q == OP_JAL) MemToReg = M2R_PC4;
        end
        default: ;
      endcase
    end
  end

  assign instret = reset ? '0 : instret_q;

endmodule
